// File: rtl/cnn_ofm_writer.sv
// Output feature map writer: snapshots a full M x R x C map on start and streams it out as one 32-bit word per beat.
// Optional macro CNN_OFM_WRITER_RELU_EN clamps negative words (bit 31 set) to zero at the output mux.
module cnn_ofm_writer #(
  parameter int M_p      = 2,
  parameter int R_p      = 4,
  parameter int C_p      = 4,
  parameter int ADDR_W_p = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [ADDR_W_p-1:0] base_addr_i,
  input  logic [31:0]         fm_i [M_p][R_p][C_p],
  output logic                busy_o,
  output logic                wr_valid_o,
  input  logic                wr_ready_i,
  output logic [ADDR_W_p-1:0] wr_addr_o,
  output logic [31:0]         wr_data_o,
  output logic                done_o
);

  localparam int MW = (M_p > 1) ? $clog2(M_p) : 1;
  localparam int RW = (R_p > 1) ? $clog2(R_p) : 1;
  localparam int CW = (C_p > 1) ? $clog2(C_p) : 1;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [MW-1:0]       r_m, w_m_nxt;
  logic [RW-1:0]       r_r, w_r_nxt;
  logic [CW-1:0]       r_c, w_c_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic [ADDR_W_p-1:0] r_addr, w_addr_nxt;
  logic [31:0]         r_data, w_data_nxt;
  logic                w_capture;
  logic                w_last;
  logic [31:0]         r_snap [M_p][R_p][C_p];

  function automatic logic [31:0] f_out(input logic [31:0] d);
`ifdef CNN_OFM_WRITER_RELU_EN
    f_out = d[31] ? 32'h0000_0000 : d;
`else
    f_out = d;
`endif
  endfunction

  // Next beat is precomputed so every output leaves a flop; the address walks linearly
  // because m-major/r/c order makes base + m*R*C + r*C + c just base plus the beat count.
  always_comb begin
    w_state_nxt = r_state;
    w_m_nxt     = r_m;
    w_r_nxt     = r_r;
    w_c_nxt     = r_c;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_capture   = 1'b0;
    w_last      = (int'(r_m) == M_p - 1) && (int'(r_r) == R_p - 1) && (int'(r_c) == C_p - 1);
    unique case (r_state)
      IDLE: begin
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        if (start_i) begin
          w_capture   = 1'b1;
          w_state_nxt = SEND;
          w_m_nxt     = '0;
          w_r_nxt     = '0;
          w_c_nxt     = '0;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_addr_nxt  = base_addr_i;
          w_data_nxt  = f_out(fm_i[0][0][0]);
        end
      end
      SEND: begin
        if (wr_ready_i) begin
          if (w_last) begin
            w_state_nxt = DONE;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            if (int'(r_c) == C_p - 1) begin
              w_c_nxt = '0;
              if (int'(r_r) == R_p - 1) begin
                w_r_nxt = '0;
                w_m_nxt = r_m + MW'(1);
              end else begin
                w_r_nxt = r_r + RW'(1);
              end
            end else begin
              w_c_nxt = r_c + CW'(1);
            end
            w_addr_nxt = r_addr + ADDR_W_p'(1);
            w_data_nxt = f_out(r_snap[w_m_nxt][w_r_nxt][w_c_nxt]);
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
      r_m     <= '0;
      r_r     <= '0;
      r_c     <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_m     <= w_m_nxt;
      r_r     <= w_r_nxt;
      r_c     <= w_c_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Snapshot lets the upstream datapath reuse its map storage while this burst drains.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int m = 0; m < M_p; m++)
        for (int r = 0; r < R_p; r++)
          for (int c = 0; c < C_p; c++)
            r_snap[m][r][c] <= '0;
    end else if (w_capture) begin
      r_snap <= fm_i;
    end
  end

  assign busy_o     = r_busy;
  assign wr_valid_o = r_valid;
  assign wr_addr_o  = r_addr;
  assign wr_data_o  = r_data;
  assign done_o     = r_done;

endmodule
